// File: rtl/chacha_xor_stream.sv
// Keystream combiner: serializes 512-bit ChaCha20 pads into 32-bit words and
// XORs them onto a packetized Avalon-ST data stream, with CSR traffic counters.
module chacha_xor_stream #(
  parameter bit DISCARD_ON_EOP = 1'b1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [511:0] pad_data,
  input  logic         pad_valid,
  output logic         pad_ready,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  input  logic         in_sop,
  input  logic         in_eop,
  output logic         in_ready,
  output logic [31:0]  out_data,
  output logic         out_valid,
  output logic         out_sop,
  output logic         out_eop,
  input  logic         out_ready,
  input  logic         csr_read,
  input  logic         csr_write,
  input  logic [1:0]   csr_address,
  input  logic [31:0]  csr_writedata,
  output logic [31:0]  csr_readdata
);

  localparam logic [31:0] PROBE = 32'h5A3C_0E71;

  typedef enum logic {EMPTY, ACTIVE} state_t;

  state_t            state;
  logic [15:0][31:0] pad;
  logic [3:0]        idx;
  logic [31:0]       words_xored, pads_loaded, pads_discarded, rd_mux;
  logic              pad_loaded, pad_fire, xfer, eop_drop, leave;
  logic              unused_wdata;

  assign unused_wdata = ^csr_writedata;

  assign pad_loaded = (state == ACTIVE);
  // Ready is a pure function of local state so the pad sink never sees out_ready.
  assign pad_ready  = !pad_loaded && !reset;
  assign in_ready   = pad_loaded && (!out_valid || out_ready) && !reset;
  assign pad_fire   = pad_valid && pad_ready;
  assign xfer       = in_valid && in_ready;
  assign eop_drop   = in_eop && DISCARD_ON_EOP;
  assign leave      = (idx == 4'd15) || eop_drop;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= EMPTY;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
    end else begin
      if (pad_fire) begin
        state <= ACTIVE;
        idx   <= '0;
      end
      if (xfer) begin
        out_data  <= in_data ^ pad[idx];
        out_sop   <= in_sop;
        out_eop   <= in_eop;
        out_valid <= 1'b1;
        idx       <= idx + 4'd1;
        if (leave) begin
          state <= EMPTY;
          idx   <= '0;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (pad_fire) pad <= pad_data;
  end

  // A write clears everything, taking priority over any same-cycle increment.
  always_ff @(posedge clock) begin
    if (reset || csr_write) begin
      words_xored    <= '0;
      pads_loaded    <= '0;
      pads_discarded <= '0;
    end else begin
      if (xfer)                             words_xored    <= words_xored + 32'd1;
      if (pad_fire)                         pads_loaded    <= pads_loaded + 32'd1;
      if (xfer && eop_drop && idx != 4'd15) pads_discarded <= pads_discarded + 32'd1;
    end
  end

  always_comb begin
    rd_mux = PROBE;
    case (csr_address)
      2'd0:    rd_mux = words_xored;
      2'd1:    rd_mux = pads_loaded;
      2'd2:    rd_mux = pads_discarded;
      default: rd_mux = PROBE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset)         csr_readdata <= '0;
    else if (csr_read) csr_readdata <= rd_mux;
  end

endmodule
